// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus stability counter producing a clean level q.
// Optional rise/fall pulses are compiled in when DEBOUNCE_EDGE_EN is defined.
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 s1_reg;
    logic                 s2_reg;
    logic                 q_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 mismatch;
    logic                 accept;

    assign mismatch = (s2_reg != q_reg);
    // cnt saturates at CNT_LAST, where the next mismatching edge accepts the level.
    assign accept   = mismatch && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg  <= 1'b0;
            s2_reg  <= 1'b0;
            q_reg   <= 1'b0;
            cnt_reg <= '0;
        end else begin
            s1_reg <= raw;
            s2_reg <= s1_reg;
            if (!mismatch) begin
                cnt_reg <= '0;
            end else if (accept) begin
                q_reg   <= s2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign q    = q_reg;
    assign busy = (cnt_reg != '0);

`ifdef DEBOUNCE_EDGE_EN
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= accept && s2_reg;
            fall_reg <= accept && !s2_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboarded bench for debounce_sync (STABLE_CYCLES=4); expectations follow
// the documented latency, with pulse expectations gated by DEBOUNCE_EDGE_EN.
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw = 1'b0;
    logic q, rise, fall, busy;

    int total = 0;
    int bad = 0;
    logic [3:0] sb[$];

    debounce_sync #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .raw(raw),
        .q(q), .rise(rise), .fall(fall), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected output vector order: {q, rise, fall, busy}.
    function automatic logic [3:0] mk(input logic eq, input logic er, input logic ef, input logic eb);
        return {eq, EDGE & er, EDGE & ef, eb};
    endfunction

    // Push the expectation, apply inputs, advance one edge, sample 1ns later.
    task automatic drive(input logic r, input logic rs, input logic [3:0] e);
        sb.push_back(e);
        raw = r;
        reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            if (k < 2) drive(1'b1, 1'b1, mk(0, 0, 0, 0));
            else       drive(1'b0, 1'b0, mk(0, 0, 0, 0));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL reset k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] e;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, mk(k >= 5, k == 5, 0, k >= 2 && k <= 4));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL clean_rise k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("clean_rise done q=%b", q);
    endtask

    task automatic test_fall();
        logic [3:0] e;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, mk(k < 5, 0, k == 5, k >= 2 && k <= 4));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL fall k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("fall done q=%b", q);
    endtask

    task automatic test_glitch();
        logic [3:0] e;
        // Three-cycle pulse drives cnt to its last value, then the bounce back resets it.
        for (int k = 0; k < 9; k++) begin
            drive(k < 3, 1'b0, mk(0, 0, 0, k >= 2 && k <= 4));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL glitch k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("glitch done q=%b", q);
    endtask

    task automatic test_bounce();
        logic [3:0] e;
        logic r;
        logic eb;
        for (int k = 0; k < 12; k++) begin
            r  = (k == 0 || k == 2 || k >= 4);
            eb = (k == 2 || k == 4 || (k >= 6 && k <= 8));
            drive(r, 1'b0, mk(k >= 9, k == 9, 0, eb));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL bounce k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("bounce done q=%b", q);
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] e;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, k == 3, mk(k >= 9, k == 9, 0, k == 2 || (k >= 6 && k <= 8)));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL reset_mid k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("reset_mid done q=%b", q);
    endtask

    task automatic test_reset_on_accept();
        logic [3:0] e;
        logic eb;
        // k=0 clears q; k=1..6 are edges 0..5 of a rise whose accepting edge is reset.
        for (int k = 0; k < 14; k++) begin
            eb = (k >= 3 && k <= 5) || (k >= 9 && k <= 11);
            drive(k != 0, k == 0 || k == 6, mk(k >= 12, k == 12, 0, eb));
            e = sb.pop_front();
            total++;
            if ({q, rise, fall, busy} !== e) begin
                bad++;
                $display("FAIL reset_accept k=%0d got qrfb=%b want=%b", k, {q, rise, fall, busy}, e);
            end
        end
        $display("reset_accept done q=%b", q);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_fall();
        test_glitch();
        test_bounce();
        test_fall();
        test_reset_mid_count();
        test_reset_on_accept();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
